// File: rtl/riscv_pkg.sv
// Shared RV32I core types: control bundle carried down the pipe and the
// forwarding-source select used by the execute-stage operand muxes.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] result_src;
    logic [3:0] alu_ctrl;
  } ctrl_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode/regfile, later pipe stages and the ID/EX
// stage. The stage itself uses the slave view; the driving side uses master.
interface id_ex_stage_if
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
);

  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic [XLEN-1:0]   id_rd1;
  logic [XLEN-1:0]   id_rd2;
  logic [XLEN-1:0]   id_imm;
  ctrl_t             id_ctrl;

  logic              ex_flush;
  logic              mem_reg_write;
  logic [REG_AW-1:0] mem_rd;
  logic [XLEN-1:0]   mem_alu_result;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_result;

  logic              stall_fd;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_imm;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  ctrl_t             ex_ctrl;
  logic [XLEN-1:0]   ex_src_a;
  logic [XLEN-1:0]   ex_src_b;
  fwd_sel_t          ex_fwd_a;
  fwd_sel_t          ex_fwd_b;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm, id_ctrl,
    output ex_flush, mem_reg_write, mem_rd, mem_alu_result,
    output wb_reg_write, wb_rd, wb_result,
    input  stall_fd, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl,
    input  ex_src_a, ex_src_b, ex_fwd_a, ex_fwd_b
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm, id_ctrl,
    input  ex_flush, mem_reg_write, mem_rd, mem_alu_result,
    input  wb_reg_write, wb_rd, wb_result,
    output stall_fd, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl,
    output ex_src_a, ex_src_b, ex_fwd_a, ex_fwd_b
  );

endinterface

// File: rtl/forward_select.sv
// EX operand forwarding mux for one source register: MEM beats WB beats the
// registered operand, and x0 or an empty EX slot never forwards.
module forward_select
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [XLEN-1:0]   reg_val_i,
  input  logic              valid_i,
  input  logic              mem_reg_write_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic [XLEN-1:0]   mem_result_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [XLEN-1:0]   wb_result_i,
  output fwd_sel_t          fwd_o,
  output logic [XLEN-1:0]   src_o
);

  always_comb begin
    fwd_o = FWD_REG;
    src_o = reg_val_i;
    if (valid_i && mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == rs_i)) begin
      fwd_o = FWD_MEM;
      src_o = mem_result_i;
    end else if (valid_i && wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == rs_i)) begin
      fwd_o = FWD_WB;
      src_o = wb_result_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with x0 forcing, same-cycle writeback bypass,
// load-use bubble insertion, branch flush and forwarded ALU operands.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  logic              ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]   ex_pc_q,    ex_pc_d;
  logic [XLEN-1:0]   ex_imm_q,   ex_imm_d;
  logic [REG_AW-1:0] ex_rs1_q,   ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q,   ex_rs2_d;
  logic [REG_AW-1:0] ex_rd_q,    ex_rd_d;
  ctrl_t             ex_ctrl_q,  ex_ctrl_d;
  logic [XLEN-1:0]   ex_op_a_q,  ex_op_a_d;
  logic [XLEN-1:0]   ex_op_b_q,  ex_op_b_d;

  logic              hazard;
  logic              load_bubble;
  logic [XLEN-1:0]   cap_a, cap_b;
  fwd_sel_t          fwd_a, fwd_b;
  logic [XLEN-1:0]   src_a, src_b;

  // The register file commits on the same edge and does not hardwire x0.
  function automatic logic [XLEN-1:0] capture(
    input logic [REG_AW-1:0] rs,
    input logic [XLEN-1:0]   rd_val,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_rd,
    input logic [XLEN-1:0]   wb_val
  );
    if (rs == '0)                              return '0;
    else if (wb_we && (wb_rd != '0) && (wb_rd == rs)) return wb_val;
    else                                       return rd_val;
  endfunction

  assign cap_a = capture(bus.id_rs1, bus.id_rd1, bus.wb_reg_write, bus.wb_rd, bus.wb_result);
  assign cap_b = capture(bus.id_rs2, bus.id_rd2, bus.wb_reg_write, bus.wb_rd, bus.wb_result);

  // Source match is conservative: made whether or not the op reads rs1/rs2.
  assign hazard = bus.id_valid & ex_valid_q & ex_ctrl_q.mem_read & (ex_rd_q != '0) &
                  ((ex_rd_q == bus.id_rs1) | (ex_rd_q == bus.id_rs2));

  assign load_bubble = bus.ex_flush | hazard | ~bus.id_valid;

  always_comb begin
    ex_valid_d = 1'b0;
    ex_pc_d    = '0;
    ex_imm_d   = '0;
    ex_rs1_d   = '0;
    ex_rs2_d   = '0;
    ex_rd_d    = '0;
    ex_ctrl_d  = '0;
    ex_op_a_d  = '0;
    ex_op_b_d  = '0;
    if (!load_bubble) begin
      ex_valid_d = 1'b1;
      ex_pc_d    = bus.id_pc;
      ex_imm_d   = bus.id_imm;
      ex_rs1_d   = bus.id_rs1;
      ex_rs2_d   = bus.id_rs2;
      ex_rd_d    = bus.id_rd;
      ex_ctrl_d  = bus.id_ctrl;
      ex_op_a_d  = cap_a;
      ex_op_b_d  = cap_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_imm_q   <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_rd_q    <= '0;
      ex_ctrl_q  <= '0;
      ex_op_a_q  <= '0;
      ex_op_b_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_pc_q    <= ex_pc_d;
      ex_imm_q   <= ex_imm_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_rd_q    <= ex_rd_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_op_a_q  <= ex_op_a_d;
      ex_op_b_q  <= ex_op_b_d;
    end
  end

  forward_select #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_a (
    .rs_i            (ex_rs1_q),
    .reg_val_i       (ex_op_a_q),
    .valid_i         (ex_valid_q),
    .mem_reg_write_i (bus.mem_reg_write),
    .mem_rd_i        (bus.mem_rd),
    .mem_result_i    (bus.mem_alu_result),
    .wb_reg_write_i  (bus.wb_reg_write),
    .wb_rd_i         (bus.wb_rd),
    .wb_result_i     (bus.wb_result),
    .fwd_o           (fwd_a),
    .src_o           (src_a)
  );

  forward_select #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_b (
    .rs_i            (ex_rs2_q),
    .reg_val_i       (ex_op_b_q),
    .valid_i         (ex_valid_q),
    .mem_reg_write_i (bus.mem_reg_write),
    .mem_rd_i        (bus.mem_rd),
    .mem_result_i    (bus.mem_alu_result),
    .wb_reg_write_i  (bus.wb_reg_write),
    .wb_rd_i         (bus.wb_rd),
    .wb_result_i     (bus.wb_result),
    .fwd_o           (fwd_b),
    .src_o           (src_b)
  );

  // A flush redirects fetch, so it must never also hold IF/ID.
  assign bus.stall_fd = hazard & ~bus.ex_flush;
  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_pc    = ex_pc_q;
  assign bus.ex_imm   = ex_imm_q;
  assign bus.ex_rs1   = ex_rs1_q;
  assign bus.ex_rs2   = ex_rs2_q;
  assign bus.ex_rd    = ex_rd_q;
  assign bus.ex_ctrl  = ex_ctrl_q;
  assign bus.ex_src_a = src_a;
  assign bus.ex_src_b = src_b;
  assign bus.ex_fwd_a = fwd_a;
  assign bus.ex_fwd_b = fwd_b;

endmodule
